interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Arbitrates the RESET, NMI and IRQ requests for the hmc-6502 core.
- Decides at instruction boundaries, signalled by the control FSM's last-cycle indication, whether to hijack the next opcode fetch.
- On a hijack it forces a BRK (0x00) into the opcode latch and supplies the vector low byte and the B value to push.
- Tracks each service until the control FSM fetches the vector.

Parameters:
- SVC_TIMEOUT, 16: max cycles from injection to vector_fetch before abort.
- TCNT_W, 5: width of the timeout counter; must hold SVC_TIMEOUT.

Ports:
- ph1 input 1: single clock; all state updates on its rising edge.
- reset input 1: synchronous, active-high reset.
- nmi_b input 1: NMI request, active-low, falling-edge sensitive.
- irq_b input 1: IRQ request, active-low, level sensitive.
- p_i input 1: processor status I flag (1 = IRQ masked).
- last_cycle input 1: control FSM is in the last cycle of the current instruction.
- vector_fetch input 1: control FSM is fetching the vector low byte (service acknowledge).
- inject output 1: force opcode 0x00 into the opcode latch this cycle.
- int_src output 2: 00 none/software BRK, 01 IRQ, 10 NMI, 11 RESET.
- vector_lo output 8: low byte of the vector address (0xFA, 0xFC or 0xFE).
- b_flag output 1: B bit value to push with P.
- busy output 1: a service sequence is in progress.
- svc_err output 1: sticky; a service timed out.

Behaviour:
- Reset values (cycle where reset=1): state=RST_INJ, int_src=11, vector_lo=0xFC, inject=0, busy=1, b_flag=0, nmi_pend=0, svc_err=0, counter=0.
  - reset asserted in any state, mid-service included, returns to these values on the next edge.
- NMI edge detect: nmi_q registers nmi_b (reset value 1).
  - nmi_q=1 && nmi_b=0 sets nmi_pend.
  - nmi_pend clears only on vector_fetch while int_src=10.
  - A new edge on the same cycle as that clear keeps nmi_pend=1 (set wins).
- IRQ is not latched. It is sampled only in IDLE when last_cycle=1.
- Priority at the decision point: RESET > NMI > IRQ.
- States:
  - IDLE: int_src=00, vector_lo=0xFE, b_flag=1 (software BRK), busy=0, inject=0.
    - last_cycle && nmi_pend -> INJ, src=10.
    - Else last_cycle && !irq_b && !p_i -> INJ, src=01.
    - Else stay in IDLE.
  - RST_INJ: inject=1 on the first cycle after reset deasserts, then -> SERVICE with src=11.
  - INJ: inject=1 for exactly one cycle (the opcode fetch following last_cycle); busy=1, b_flag=0; counter cleared -> SERVICE.
  - SERVICE: inject=0, busy=1, counter increments each cycle.
    - vector_fetch -> IDLE (clear nmi_pend if src=10).
    - Counter reaches SVC_TIMEOUT without vector_fetch -> IDLE, set svc_err; nmi_pend is retained.
- vector_lo encoding: src=10 -> 0xFA; src=11 -> 0xFC; src=01 or 00 -> 0xFE.
- Outputs are registered; int_src, vector_lo and b_flag are stable from INJ until the cycle after vector_fetch.
- last_cycle outside IDLE is ignored; no nested injection.
- IRQ deasserted after the decision does not cancel the service.
- vector_fetch in IDLE is ignored (software BRK path).

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: if nmi_pend becomes 1 while in SERVICE with src=01, on or before the vector_fetch cycle:
  - int_src switches to 10 and vector_lo to 0xFA on the next edge;
  - b_flag stays 0;
  - the vector_fetch then clears nmi_pend.
  - If the edge arrives on the vector_fetch cycle itself, no hijack occurs; NMI is serviced at the next boundary.
- Undefined: no hijack. NMI always waits for the next IDLE decision point.

Test Plan:
- Reset 3 cycles then release -> inject=1 on the first post-reset cycle, int_src=11, vector_lo=0xFC; after vector_fetch, busy=0, int_src=00, vector_lo=0xFE, b_flag=1.
- irq_b=0, p_i=0, pulse last_cycle -> next cycle inject=1, int_src=01, vector_lo=0xFE, b_flag=0; vector_fetch 4 cycles later -> IDLE. Repeat with p_i=1 -> inject stays 0.
- nmi_b 1->0 held low, two last_cycle pulses separated by a vector_fetch -> exactly one NMI service (vector_lo=0xFA); the second boundary yields no inject.
- nmi_b falling edge and irq_b=0 together at one last_cycle -> int_src=10 first; after its vector_fetch, the next last_cycle serves IRQ (int_src=01).
- Inject with no vector_fetch for 16 cycles -> return to IDLE at cycle 16, svc_err=1 and stays 1 until reset.
- With NMI_HIJACK_EN, IRQ service then an NMI edge 2 cycles later -> vector_lo becomes 0xFA before vector_fetch and nmi_pend clears after it. Without the macro -> vector_lo stays 0xFE and NMI is served at the next boundary.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// RESET/NMI/IRQ arbiter for the hmc-6502 core: hijacks the opcode fetch with BRK at instruction boundaries.
// Optional NMI_HIJACK_EN: a pending NMI takes over an IRQ service before its vector fetch.
//   state   | meaning
//   IDLE    | no service; software BRK values presented
//   RST_INJ | reset seen; arm the reset injection
//   INJ     | inject=1 for the hijacked opcode fetch
//   SERVICE | waiting for vector_fetch or timeout
module interrupt_sequencer #(
    parameter int SVC_TIMEOUT = 16,
    parameter int TCNT_W      = 5
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic       nmi_b,
    input  logic       irq_b,
    input  logic       p_i,
    input  logic       last_cycle,
    input  logic       vector_fetch,
    output logic       inject,
    output logic [1:0] int_src,
    output logic [7:0] vector_lo,
    output logic       b_flag,
    output logic       busy,
    output logic       svc_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RST_INJ = 2'd1,
        INJ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_IRQ  = 2'b01;
    localparam logic [1:0] SRC_NMI  = 2'b10;
    localparam logic [1:0] SRC_RST  = 2'b11;
    localparam logic [TCNT_W-1:0] CNT_TO = TCNT_W'(SVC_TIMEOUT);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_int_src, w_src_nxt;
    logic [7:0]        r_vector_lo, w_vl_nxt;
    logic              r_inject, w_inj_nxt;
    logic              r_b_flag, w_b_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_svc_err, w_err_nxt;
    logic [TCNT_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_nmi_q;
    logic              r_nmi_pend;
    logic              w_nmi_edge;
    logic              w_nmi_req;
    logic              w_nmi_clr;
    logic              w_pend_nxt;

    // The same-cycle edge is honoured so an NMI arriving with last_cycle beats IRQ.
    assign w_nmi_edge = r_nmi_q & ~nmi_b;
    assign w_nmi_req  = r_nmi_pend | w_nmi_edge;
    assign w_nmi_clr  = (r_state == SERVICE) && vector_fetch && (r_int_src == SRC_NMI);
    assign w_pend_nxt = w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state     <= RST_INJ;
            r_int_src   <= SRC_RST;
            r_vector_lo <= 8'hFC;
            r_inject    <= 1'b0;
            r_b_flag    <= 1'b0;
            r_busy      <= 1'b1;
            r_svc_err   <= 1'b0;
            r_cnt       <= '0;
            r_nmi_q     <= 1'b1;
            r_nmi_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_int_src   <= w_src_nxt;
            r_vector_lo <= w_vl_nxt;
            r_inject    <= w_inj_nxt;
            r_b_flag    <= w_b_nxt;
            r_busy      <= w_busy_nxt;
            r_svc_err   <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_nmi_q     <= nmi_b;
            r_nmi_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_int_src;
        w_vl_nxt    = r_vector_lo;
        w_inj_nxt   = 1'b0;
        w_b_nxt     = r_b_flag;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_svc_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RST_INJ: begin
                w_state_nxt = INJ;
                w_inj_nxt   = 1'b1;
                w_src_nxt   = SRC_RST;
                w_vl_nxt    = 8'hFC;
                w_b_nxt     = 1'b0;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = '0;
            end
            INJ: begin
                w_state_nxt = SERVICE;
                w_cnt_nxt   = r_cnt + 1'b1;
            end
            SERVICE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (vector_fetch || (w_cnt_nxt == CNT_TO)) begin
                    w_state_nxt = IDLE;
                    w_src_nxt   = SRC_NONE;
                    w_vl_nxt    = 8'hFE;
                    w_b_nxt     = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    if (!vector_fetch)
                        w_err_nxt = 1'b1;
                end
`ifdef NMI_HIJACK_EN
                else if ((r_int_src == SRC_IRQ) && r_nmi_pend) begin
                    w_src_nxt = SRC_NMI;
                    w_vl_nxt  = 8'hFA;
                end
`endif
            end
            default: begin
                if (last_cycle && (w_nmi_req || (!irq_b && !p_i))) begin
                    w_state_nxt = INJ;
                    w_inj_nxt   = 1'b1;
                    w_src_nxt   = w_nmi_req ? SRC_NMI : SRC_IRQ;
                    w_vl_nxt    = w_nmi_req ? 8'hFA : 8'hFE;
                    w_b_nxt     = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign inject    = r_inject;
    assign int_src   = r_int_src;
    assign vector_lo = r_vector_lo;
    assign b_flag    = r_b_flag;
    assign busy      = r_busy;
    assign svc_err   = r_svc_err;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; expectations follow NMI_HIJACK_EN when defined.
module tb_interrupt_sequencer;

    logic       ph1 = 1'b0;
    logic       reset = 1'b1;
    logic       nmi_b = 1'b1;
    logic       irq_b = 1'b1;
    logic       p_i = 1'b0;
    logic       last_cycle = 1'b0;
    logic       vector_fetch = 1'b0;
    logic       inject;
    logic [1:0] int_src;
    logic [7:0] vector_lo;
    logic       b_flag;
    logic       busy;
    logic       svc_err;

    int n_checks = 0;
    int n_err = 0;

    interrupt_sequencer #(.SVC_TIMEOUT(16), .TCNT_W(5)) dut (
        .ph1(ph1), .reset(reset), .nmi_b(nmi_b), .irq_b(irq_b), .p_i(p_i),
        .last_cycle(last_cycle), .vector_fetch(vector_fetch),
        .inject(inject), .int_src(int_src), .vector_lo(vector_lo),
        .b_flag(b_flag), .busy(busy), .svc_err(svc_err)
    );

    always #5 ph1 = ~ph1;

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the full output bundle: inject, int_src, vector_lo, b_flag, busy.
    task automatic chk_all(input string tag, input logic i, input logic [1:0] s,
                           input logic [7:0] v, input logic b, input logic bz);
        chk({tag, ".inject"}, {7'd0, inject}, {7'd0, i});
        chk({tag, ".int_src"}, {6'd0, int_src}, {6'd0, s});
        chk({tag, ".vector_lo"}, vector_lo, v);
        chk({tag, ".b_flag"}, {7'd0, b_flag}, {7'd0, b});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
    endtask

    initial begin
        // Reset held three cycles, then the reset service.
        tick(); tick(); tick();
        chk_all("rst_hold", 1'b0, 2'b11, 8'hFC, 1'b0, 1'b1);
        chk("rst_err", {7'd0, svc_err}, 8'd0);
        reset = 1'b0;
        tick();
        chk_all("rst_inj", 1'b1, 2'b11, 8'hFC, 1'b0, 1'b1);
        tick();
        chk_all("rst_svc", 1'b0, 2'b11, 8'hFC, 1'b0, 1'b1);
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        chk_all("rst_done", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);

        // IRQ service; deasserting irq_b after the decision must not cancel it.
        irq_b = 1'b0; p_i = 1'b0; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1;
        chk_all("irq_inj", 1'b1, 2'b01, 8'hFE, 1'b0, 1'b1);
        tick();
        chk_all("irq_svc", 1'b0, 2'b01, 8'hFE, 1'b0, 1'b1);
        tick(); tick(); tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        chk_all("irq_done", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);

        // Masked IRQ yields nothing.
        irq_b = 1'b0; p_i = 1'b1; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1; p_i = 1'b0;
        chk_all("irq_masked", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);

        // NMI held low: one service only.
        nmi_b = 1'b0;
        tick();
        last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0;
        chk_all("nmi_inj", 1'b1, 2'b10, 8'hFA, 1'b0, 1'b1);
        tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        chk_all("nmi_done", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);
        last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0;
        chk_all("nmi_once", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        chk_all("vf_in_idle", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);
        nmi_b = 1'b1;
        tick();

        // NMI edge and IRQ at the same boundary: NMI first, then IRQ.
        nmi_b = 1'b0; irq_b = 1'b0; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0;
        chk_all("prio_nmi", 1'b1, 2'b10, 8'hFA, 1'b0, 1'b1);
        tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1; nmi_b = 1'b1;
        chk_all("prio_irq", 1'b1, 2'b01, 8'hFE, 1'b0, 1'b1);
        tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        chk_all("prio_done", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);

        // Timeout: inject at c0, service c1..c15, idle at c16.
        irq_b = 1'b0; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        chk("to_busy15", {7'd0, busy}, 8'd1);
        chk("to_err15", {7'd0, svc_err}, 8'd0);
        tick();
        chk_all("to_idle16", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);
        chk("to_err16", {7'd0, svc_err}, 8'd1);
        irq_b = 1'b0; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1;
        tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        chk("err_sticky", {7'd0, svc_err}, 8'd1);

        // Reset mid-service restores reset values and clears svc_err.
        irq_b = 1'b0; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk_all("rst_mid", 1'b0, 2'b11, 8'hFC, 1'b0, 1'b1);
        chk("rst_mid_err", {7'd0, svc_err}, 8'd0);
        reset = 1'b0;
        tick(); tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;

        // NMI edge during an IRQ service.
        irq_b = 1'b0; last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; irq_b = 1'b1;
        tick();
        nmi_b = 1'b0;
        tick();
        tick();
`ifdef NMI_HIJACK_EN
        chk_all("hij_switch", 1'b0, 2'b10, 8'hFA, 1'b0, 1'b1);
`else
        chk_all("hij_none", 1'b0, 2'b01, 8'hFE, 1'b0, 1'b1);
`endif
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
        last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0;
`ifdef NMI_HIJACK_EN
        chk_all("hij_cleared", 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0);
`else
        chk_all("hij_next_nmi", 1'b1, 2'b10, 8'hFA, 1'b0, 1'b1);
        tick();
        vector_fetch = 1'b1;
        tick();
        vector_fetch = 1'b0;
`endif
        chk("final_err", {7'd0, svc_err}, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
